// File: rtl/menu_pkg.sv
// Shared types and constants for the difficulty/speed selection page controller.
package menu_pkg;

  typedef enum logic [1:0] {
    ST_MENU,
    ST_CONFIRM,
    ST_LAUNCH,
    ST_PLAY
  } menu_state_t;

  localparam logic [1:0] HARD_EASY   = 2'd0;
  localparam logic [1:0] HARD_NORMAL = 2'd1;
  localparam logic [1:0] HARD_HARD   = 2'd2;

  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_ENTER = 4;
  localparam int unsigned KEY_W     = 5;

  // Saturating difficulty step in either direction, clamped to 0..hmax.
  function automatic logic [1:0] hard_step(input logic [1:0] h, input logic inc,
                                           input logic [1:0] hmax);
    logic [1:0] r;
    if (inc) r = (h >= hmax) ? hmax : h + 2'd1;
    else     r = (h == 2'd0) ? 2'd0 : h - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/menu_key_edge.sv
// Press detector for the 5-bit key vector; previous-value registers reset to 1
// so keys held through reset never register as a press.
module menu_key_edge
  import menu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [KEY_W-1:0] i_keys,
  output logic [KEY_W-1:0] o_press
);

  logic [KEY_W-1:0] r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= '1;
    else       r_prev <= i_keys;
  end

  assign o_press = i_keys & ~r_prev;

endmodule

// File: rtl/menu_select_ctrl.sv
// Selection page controller: cursor/difficulty/speed settings and the
// confirm -> launch -> play sequence. Optional hold-to-repeat: MENU_AUTO_REPEAT_EN.
module menu_select_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned CONFIRM_CYCLES = 8,
  parameter int unsigned HARD_MAX       = 2,
  parameter int unsigned REPEAT_DELAY   = 12,
  parameter int unsigned REPEAT_PERIOD  = 4
) (
  input  logic       clk_22,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_enter,
  input  logic       game_over,
  output logic       up,
  output logic [1:0] hard,
  output logic       speed,
  output logic       blink,
  output logic       game_start,
  output logic       in_game
);

  // Counter kept at least 2 bits wide so blink can always read bit 1.
  localparam int unsigned CW = ($clog2(CONFIRM_CYCLES) < 2) ? 2 : $clog2(CONFIRM_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CONFIRM_CYCLES - 1);
  localparam logic [1:0]    HMAX     = 2'(HARD_MAX);

  menu_state_t      r_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_dec;
  logic [KEY_W-1:0] w_keys;
  logic [KEY_W-1:0] w_press;
  logic             w_rep_fire;
  logic             w_rep_inc;

  assign w_keys    = {key_enter, key_right, key_left, key_down, key_up};
  assign w_cnt_dec = r_cnt - CW'(1);

  menu_key_edge u_key_edge (
    .i_clk   (clk_22),
    .i_rst   (rst),
    .i_keys  (w_keys),
    .o_press (w_press)
  );

`ifdef MENU_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] r_hold_cnt;
  logic          r_hold_right;
  logic          w_hold_l;
  logic          w_hold_r;
  logic          w_hold;
  logic          w_hold_same;

  assign w_hold_l    = (r_state == ST_MENU) && !up && key_left && !key_right;
  assign w_hold_r    = (r_state == ST_MENU) && !up && key_right && !key_left;
  assign w_hold      = w_hold_l || w_hold_r;
  assign w_hold_same = (r_hold_cnt != '0) && (r_hold_right == w_hold_r);
  assign w_rep_fire  = w_hold && w_hold_same && (r_hold_cnt == RW'(REPEAT_DELAY));
  assign w_rep_inc   = w_hold_r;

  // After a repeat the counter rewinds so the next one lands REPEAT_PERIOD later.
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      r_hold_cnt   <= '0;
      r_hold_right <= 1'b0;
    end else if (!w_hold) begin
      r_hold_cnt   <= '0;
    end else if (!w_hold_same) begin
      r_hold_cnt   <= RW'(1);
      r_hold_right <= w_hold_r;
    end else if (w_rep_fire) begin
      r_hold_cnt   <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    end else begin
      r_hold_cnt   <= r_hold_cnt + RW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
  assign w_rep_inc  = 1'b0;
`endif

  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      r_state    <= ST_MENU;
      r_cnt      <= '0;
      up         <= 1'b0;
      hard       <= HARD_EASY;
      speed      <= 1'b0;
      blink      <= 1'b0;
      game_start <= 1'b0;
      in_game    <= 1'b0;
    end else begin
      case (r_state)
        ST_MENU: begin
          if (w_press[KEY_ENTER]) begin
            r_state <= ST_CONFIRM;
            r_cnt   <= CNT_LOAD;
            blink   <= CNT_LOAD[1];
          end else if (w_press[KEY_UP]) begin
            up <= 1'b0;
          end else if (w_press[KEY_DOWN]) begin
            up <= 1'b1;
          end else if (w_press[KEY_LEFT]) begin
            if (up) speed <= ~speed;
            else    hard  <= hard_step(hard, 1'b0, HMAX);
          end else if (w_press[KEY_RIGHT]) begin
            if (up) speed <= ~speed;
            else    hard  <= hard_step(hard, 1'b1, HMAX);
          end else if (w_rep_fire) begin
            hard <= hard_step(hard, w_rep_inc, HMAX);
          end
        end
        ST_CONFIRM: begin
          if (r_cnt == '0) begin
            r_state    <= ST_LAUNCH;
            blink      <= 1'b0;
            game_start <= 1'b1;
          end else begin
            r_cnt <= w_cnt_dec;
            blink <= w_cnt_dec[1];
          end
        end
        ST_LAUNCH: begin
          r_state    <= ST_PLAY;
          game_start <= 1'b0;
          in_game    <= 1'b1;
        end
        ST_PLAY: begin
          if (game_over) begin
            r_state <= ST_MENU;
            in_game <= 1'b0;
          end
        end
        default: r_state <= ST_MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_menu_select_ctrl.sv
// Bench for menu_select_ctrl: cycle-level behavioural model plus directed vectors.
module tb_menu_select_ctrl;

  localparam int CC = 8;
  localparam int HM = 2;
  localparam int RD = 12;
  localparam int RP = 4;
  localparam int K_UP = 0, K_DN = 1, K_LT = 2, K_RT = 3, K_EN = 4;

  logic       clk;
  logic       rst;
  logic [4:0] keys;
  logic       game_over;
  logic       up, speed, blink, game_start, in_game;
  logic [1:0] hard;

  int checks = 0;
  int errors = 0;

  menu_select_ctrl #(
    .CONFIRM_CYCLES (CC),
    .HARD_MAX       (HM),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_22     (clk),
    .rst        (rst),
    .key_up     (keys[K_UP]),
    .key_down   (keys[K_DN]),
    .key_left   (keys[K_LT]),
    .key_right  (keys[K_RT]),
    .key_enter  (keys[K_EN]),
    .game_over  (game_over),
    .up         (up),
    .hard       (hard),
    .speed      (speed),
    .blink      (blink),
    .game_start (game_start),
    .in_game    (in_game)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t = -1 in menu, otherwise cycles elapsed since enter was accepted.
  int         m_t, m_up, m_hard, m_speed, m_run, m_dir;
  logic [4:0] m_prev;

  always @(posedge clk or posedge rst) begin : model
    logic [4:0] pr;
    int dir;
    bit fire;
    if (rst) begin
      m_t = -1; m_up = 0; m_hard = 0; m_speed = 0;
      m_prev = '1; m_run = 0; m_dir = 0;
    end else begin
      pr = keys & ~m_prev;
      m_prev = keys;
      fire = 0;
`ifdef MENU_AUTO_REPEAT_EN
      dir = 0;
      if (m_t == -1 && m_up == 0 && keys[K_LT] && !keys[K_RT]) dir = 1;
      if (m_t == -1 && m_up == 0 && keys[K_RT] && !keys[K_LT]) dir = 2;
      if (dir == 0) m_run = 0;
      else if (m_run == 0 || dir != m_dir) begin m_run = 1; m_dir = dir; end
      else m_run++;
      fire = (dir != 0) && (m_run - 1 >= RD) && (((m_run - 1 - RD) % RP) == 0);
`else
      dir = 0;
`endif
      if (m_t == -1) begin
        if (pr[K_EN]) m_t = 0;
        else if (pr[K_UP]) m_up = 0;
        else if (pr[K_DN]) m_up = 1;
        else if (pr[K_LT] || pr[K_RT]) begin
          if (m_up == 1) m_speed = 1 - m_speed;
          else if (pr[K_LT]) m_hard = (m_hard > 0) ? m_hard - 1 : 0;
          else m_hard = (m_hard < HM) ? m_hard + 1 : HM;
        end else if (fire) begin
          if (dir == 2) m_hard = (m_hard < HM) ? m_hard + 1 : HM;
          else m_hard = (m_hard > 0) ? m_hard - 1 : 0;
        end
      end else if (m_t <= CC) begin
        m_t++;
      end else if (game_over) begin
        m_t = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("up", up, m_up);
      chk("hard", hard, m_hard);
      chk("speed", speed, m_speed);
      chk("blink", blink, (m_t >= 0 && m_t < CC) ? (((CC - 1 - m_t) / 2) % 2) : 0);
      chk("game_start", game_start, (m_t == CC) ? 1 : 0);
      chk("in_game", in_game, (m_t == CC + 1) ? 1 : 0);
    end
  end

  task automatic press(input int idx);
    keys[idx] = 1'b1;
    @(negedge clk);
    keys[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_up", up, 0);
    chk("rst_hard", hard, 0);
    chk("rst_speed", speed, 0);
    chk("rst_blink", blink, 0);
    chk("rst_game_start", game_start, 0);
    chk("rst_in_game", in_game, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int inc_exp[4] = '{1, 2, 2, 2};
    int dec_exp[3] = '{1, 0, 0};
    int bl_exp[10] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};

    rst = 1'b1; keys = '0; game_over = 1'b0;
    keys[K_RT] = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_through_reset", hard, 0);
    keys[K_RT] = 1'b0;
    @(negedge clk);
    press(K_RT);
    chk("first_press", hard, 1);
    press(K_LT);
    chk("back_to_0", hard, 0);

    for (int i = 0; i < 4; i++) begin
      press(K_RT);
      chk("right_sat", hard, inc_exp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      press(K_LT);
      chk("left_sat", hard, dec_exp[i]);
    end

    press(K_DN);
    chk("down_row", up, 1);
    press(K_RT);
    chk("speed_on", speed, 1);
    press(K_RT);
    chk("speed_off", speed, 0);
    keys[K_UP] = 1'b1; keys[K_DN] = 1'b1;
    @(negedge clk);
    keys = '0;
    @(negedge clk);
    chk("up_beats_down", up, 0);

    press(K_RT);
    press(K_RT);
    press(K_DN);
    press(K_RT);
    press(K_UP);
    chk("setup_hard", hard, 2);
    chk("setup_speed", speed, 1);

    keys[K_EN] = 1'b1;
    @(negedge clk);
    keys[K_EN] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("win_blink", blink, bl_exp[c-1]);
      chk("win_game_start", game_start, (c == 9) ? 1 : 0);
      chk("win_in_game", in_game, (c == 10) ? 1 : 0);
      if (c < 10) begin
        keys[K_LT] = c[0];
        @(negedge clk);
      end
    end
    keys[K_LT] = 1'b0;
    chk("frozen_hard", hard, 2);
    press(K_LT);
    press(K_DN);
    chk("play_ignores_keys", hard, 2);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    chk("over_in_game", in_game, 0);
    chk("over_hard", hard, 2);
    chk("over_speed", speed, 1);
    chk("over_up", up, 0);
    repeat (2) @(negedge clk);

    press(K_DN);
    keys[K_EN] = 1'b1;
    @(negedge clk);
    keys[K_EN] = 1'b0;
    @(negedge clk);
    chk("pre_rst_blink", blink, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_in_game", in_game, 0);

`ifdef MENU_AUTO_REPEAT_EN
    keys[K_RT] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("repeat_hard", hard, (c < 13) ? 1 : 2);
    end
    keys[K_RT] = 1'b0;
    keys[K_LT] = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk("repeat_left", hard, (c < 13) ? 1 : ((c < 17) ? 0 : 0));
    end
    keys[K_LT] = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
